// File: rtl/duck_sprite_fetch.sv
// Duck sprite fetch-and-colour pipeline: frame latch, animation, hit test, RAM address, palette.
// Optional horizontal mirroring is enabled by defining DUCK_MIRROR_EN (adds input h_flip).
module duck_sprite_fetch #(
  parameter int unsigned SPRITE_W   = 20,
  parameter int unsigned SPRITE_H   = 20,
  parameter int unsigned FLY_FRAMES = 3,
  parameter int unsigned ANIM_DIV   = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  duck_x,
  input  logic [9:0]  duck_y,
  input  logic [1:0]  duck_state,
`ifdef DUCK_MIRROR_EN
  input  logic        h_flip,
`endif
  output logic [18:0] read_address,
  input  logic [4:0]  data_In,
  output logic        sprite_on,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue
);

  localparam int unsigned AW = 19;
  localparam int unsigned DW = 11;
  localparam int unsigned FW = $clog2(FLY_FRAMES + 3);
  localparam int unsigned CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  typedef enum logic [1:0] {
    ST_FLYING  = 2'b00,
    ST_SHOT    = 2'b01,
    ST_FALLING = 2'b10,
    ST_HIDDEN  = 2'b11
  } duck_st_e;

  // Latched per-frame copies of the sprite inputs.
  logic           r_fclk_d;
  logic [9:0]     r_x;
  logic [9:0]     r_y;
  duck_st_e       r_state;
  logic [FW-1:0]  r_frame;
  logic [CW-1:0]  r_cnt;
  logic           r_hit1;
  logic           r_hit2;
`ifdef DUCK_MIRROR_EN
  logic           r_flip;
  logic           w_flip;
`endif

  logic           w_edge;
  duck_st_e       w_st_in;
  logic           w_wrap;
  logic [FW-1:0]  w_frame_nxt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [9:0]     w_x;
  logic [9:0]     w_y;
  duck_st_e       w_state;
  logic [FW-1:0]  w_frame;
  logic [DW-1:0]  w_dx;
  logic [DW-1:0]  w_dy;
  logic [DW-1:0]  w_col;
  logic           w_hit;
  logic [AW-1:0]  w_addr;
  logic           w_opaque;

  function automatic logic [23:0] palette(input logic [4:0] idx);
    logic [23:0] rgb;
    case (idx)
      5'd0:    rgb = 24'h000000;
      5'd1:    rgb = 24'h000000;
      5'd2:    rgb = 24'hFFFFFF;
      5'd3:    rgb = 24'h8B4513;
      5'd4:    rgb = 24'h00A000;
      5'd5:    rgb = 24'hFFD000;
      default: rgb = 24'h808080;
    endcase
    return rgb;
  endfunction

  assign w_edge  = frame_clk & ~r_fclk_d;
  assign w_st_in = duck_st_e'(duck_state);
  assign w_wrap  = (r_cnt == CW'(ANIM_DIV - 1));

  // Next animation frame/counter, evaluated against the incoming state.
  always_comb begin
    w_frame_nxt = r_frame;
    w_cnt_nxt   = r_cnt;
    case (w_st_in)
      ST_FLYING: begin
        if (r_state != ST_FLYING) begin
          w_frame_nxt = '0;
          w_cnt_nxt   = '0;
        end else if (w_wrap) begin
          w_cnt_nxt   = '0;
          w_frame_nxt = (r_frame == FW'(FLY_FRAMES - 1)) ? '0 : FW'(r_frame + 1'b1);
        end else begin
          w_cnt_nxt   = CW'(r_cnt + 1'b1);
        end
      end
      ST_SHOT: begin
        w_frame_nxt = FW'(FLY_FRAMES);
        w_cnt_nxt   = '0;
      end
      ST_FALLING: begin
        if (r_state != ST_FALLING) begin
          w_frame_nxt = FW'(FLY_FRAMES + 1);
          w_cnt_nxt   = '0;
        end else if (w_wrap) begin
          w_cnt_nxt   = '0;
          w_frame_nxt = (r_frame == FW'(FLY_FRAMES + 1)) ? FW'(FLY_FRAMES + 2)
                                                         : FW'(FLY_FRAMES + 1);
        end else begin
          w_cnt_nxt   = CW'(r_cnt + 1'b1);
        end
      end
      default: begin
        w_frame_nxt = r_frame;
        w_cnt_nxt   = r_cnt;
      end
    endcase
  end

  // The pixel in the edge cycle already sees the freshly latched values.
  assign w_x     = w_edge ? duck_x      : r_x;
  assign w_y     = w_edge ? duck_y      : r_y;
  assign w_state = w_edge ? w_st_in     : r_state;
  assign w_frame = w_edge ? w_frame_nxt : r_frame;
`ifdef DUCK_MIRROR_EN
  assign w_flip  = w_edge ? h_flip      : r_flip;
`endif

  assign w_dx = DW'({1'b0, DrawX}) - DW'({1'b0, w_x});
  assign w_dy = DW'({1'b0, DrawY}) - DW'({1'b0, w_y});

  // A set sign bit means the scan is left of / above the box.
  assign w_hit = ~w_dx[DW-1] && (w_dx < DW'(SPRITE_W)) &&
                 ~w_dy[DW-1] && (w_dy < DW'(SPRITE_H)) &&
                 (w_state != ST_HIDDEN);

`ifdef DUCK_MIRROR_EN
  assign w_col = w_flip ? DW'(DW'(SPRITE_W - 1) - w_dx) : w_dx;
`else
  assign w_col = w_dx;
`endif

  assign w_addr = AW'(AW'(w_frame) * AW'(SPRITE_W * SPRITE_H)) +
                  AW'(AW'(w_dy) * AW'(SPRITE_W)) + AW'(w_col);

  assign w_opaque = r_hit2 && (data_In != 5'd0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fclk_d     <= 1'b1;
      r_x          <= '0;
      r_y          <= '0;
      r_state      <= ST_HIDDEN;
      r_frame      <= '0;
      r_cnt        <= '0;
`ifdef DUCK_MIRROR_EN
      r_flip       <= 1'b0;
`endif
      read_address <= '0;
      r_hit1       <= 1'b0;
      r_hit2       <= 1'b0;
      sprite_on    <= 1'b0;
      Red          <= '0;
      Green        <= '0;
      Blue         <= '0;
    end else begin
      r_fclk_d <= frame_clk;
      if (w_edge) begin
        r_x     <= duck_x;
        r_y     <= duck_y;
        r_state <= w_st_in;
        r_frame <= w_frame_nxt;
        r_cnt   <= w_cnt_nxt;
`ifdef DUCK_MIRROR_EN
        r_flip  <= h_flip;
`endif
      end
      if (w_hit) begin
        read_address <= w_addr;
      end
      r_hit1    <= w_hit;
      r_hit2    <= r_hit1;
      sprite_on <= w_opaque;
      {Red, Green, Blue} <= w_opaque ? palette(data_In) : 24'h000000;
    end
  end

endmodule

// File: tb/tb_duck_sprite_fetch.sv
// Randomised scoreboard bench for duck_sprite_fetch with a frame-level reference model.
module tb_duck_sprite_fetch;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b1;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [9:0]  duck_x = '0;
  logic [9:0]  duck_y = '0;
  logic [1:0]  duck_state = 2'b11;
  logic [18:0] read_address;
  logic [4:0]  data_In = '0;
  logic        sprite_on;
  logic [7:0]  Red;
  logic [7:0]  Green;
  logic [7:0]  Blue;

  always #5 Clk = ~Clk;

  duck_sprite_fetch dut (
    .Clk(Clk),
    .Reset(Reset),
    .frame_clk(frame_clk),
    .DrawX(DrawX),
    .DrawY(DrawY),
    .duck_x(duck_x),
    .duck_y(duck_y),
    .duck_state(duck_state),
`ifdef DUCK_MIRROR_EN
    .h_flip(1'b0),
`endif
    .read_address(read_address),
    .data_In(data_In),
    .sprite_on(sprite_on),
    .Red(Red),
    .Green(Green),
    .Blue(Blue)
  );

  typedef struct {
    int addr;
    int on;
    int rgb;
  } exp_t;

  exp_t q[$];
  logic [4:0] mem [0:2399];
  int total = 0;
  int bad = 0;

  // Sprite frame RAM: registered read, one clock of latency.
  always @(posedge Clk)
    data_In <= (read_address < 19'd2400) ? mem[read_address] : 5'd0;

  // Reference model state: latched inputs and edges since entering the current state.
  int   m_st = 3, m_x = 0, m_y = 0, m_n = 0, m_addr = 0;
  bit   m_prev = 1'b1;
  exp_t p1 = '{0, 0, 0};
  exp_t p2 = '{0, 0, 0};
  int   s_x = 0, s_y = 0, s_st = 3;

  function automatic int pal(input int idx);
    case (idx)
      1: return 32'h000000;
      2: return 32'hFFFFFF;
      3: return 32'h8B4513;
      4: return 32'h00A000;
      5: return 32'hFFD000;
      default: return (idx == 0) ? 0 : 32'h808080;
    endcase
  endfunction

  function automatic int model_frame(input int st, input int n);
    case (st)
      0: return (n / 8) % 3;
      1: return 3;
      2: return 4 + (n / 8) % 2;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Drive one pixel cycle and push the expected post-edge outputs.
  task automatic step(input bit rst, input bit fc, input int px, input int py);
    exp_t e, cur;
    int ddx, ddy, idx;
    bit hit;
    @(negedge Clk);
    Reset = rst; frame_clk = fc;
    DrawX = 10'(px); DrawY = 10'(py);
    duck_x = 10'(s_x); duck_y = 10'(s_y); duck_state = 2'(s_st);
    e = '{0, 0, 0};
    if (rst) begin
      m_prev = 1'b1; m_st = 3; m_x = 0; m_y = 0; m_n = 0; m_addr = 0;
      p1 = '{0, 0, 0}; p2 = '{0, 0, 0};
    end else begin
      if (fc && !m_prev) begin
        m_n  = (int'(duck_state) == m_st) ? m_n + 1 : 0;
        m_st = int'(duck_state); m_x = int'(duck_x); m_y = int'(duck_y);
      end
      m_prev = fc;
      ddx = int'(DrawX) - m_x;
      ddy = int'(DrawY) - m_y;
      hit = (ddx >= 0) && (ddx < 20) && (ddy >= 0) && (ddy < 20) && (m_st != 3);
      if (hit) m_addr = model_frame(m_st, m_n) * 400 + ddy * 20 + ddx;
      cur = '{m_addr, 0, 0};
      if (hit) begin
        idx = int'(mem[m_addr]);
        cur.on  = (idx != 0) ? 1 : 0;
        cur.rgb = (idx != 0) ? pal(idx) : 0;
      end
      e = '{m_addr, p2.on, p2.rgb};
      p2 = p1; p1 = cur;
    end
    q.push_back(e);
  endtask

  // One video frame: edge cycle at the box origin, then pixels scattered round the latched box
  // while duck_x/duck_y wander without being latched.
  task automatic frame(input int st, input bit move);
    if (move) begin
      s_x = $urandom_range(0, 630);
      s_y = $urandom_range(0, 470);
    end
    s_st = st;
    step(0, 1, s_x, s_y);
    for (int i = 0; i < 5; i++) begin
      s_x = $urandom_range(0, 630);
      step(0, 0, m_x + $urandom_range(0, 24) - 2, m_y + $urandom_range(0, 24) - 2);
    end
  endtask

  // Monitor: one expectation per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("read_address", int'(read_address), e.addr);
        chk("sprite_on", int'(sprite_on), e.on);
        chk("rgb", int'({Red, Green, Blue}), e.rgb);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2400; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'(($urandom_range(1, 31)));
    mem[45] = 5'd3;
    mem[46] = 5'd0;

    // Reset with frame_clk high, then hold it high: no edge may be seen.
    s_x = 100; s_y = 50; s_st = 0;
    repeat (3) step(1, 1, 105, 52);
    repeat (5) step(0, 1, 105, 52);

    // First real edge latches FLYING at (100,50); edge-cycle pixel hits address 45.
    step(0, 0, 105, 52);
    step(0, 1, 105, 52);
    step(0, 0, 99, 52);
    step(0, 0, 120, 52);
    step(0, 0, 106, 52);
    s_x = 300;
    step(0, 0, 100, 50);
    step(0, 0, 119, 69);
    step(0, 0, 100, 70);
    s_x = 100;

    // Animation sequence: FLYING 24, SHOT, FALLING 20, HIDDEN, back to FLYING.
    for (int i = 0; i < 24; i++) frame(0, 0);
    for (int i = 0; i < 4; i++)  frame(1, 1);
    for (int i = 0; i < 20; i++) frame(2, 0);
    for (int i = 0; i < 3; i++)  frame(3, 1);
    for (int i = 0; i < 10; i++) frame(0, 1);

    // Random states and positions.
    for (int i = 0; i < 40; i++) frame($urandom_range(0, 3), $urandom_range(0, 1) == 1);

    // Reset mid-frame with the pipeline full, released with frame_clk high.
    s_st = 0;
    step(0, 0, m_x + 3, m_y + 3);
    step(1, 0, m_x + 4, m_y + 3);
    step(1, 1, m_x + 5, m_y + 3);
    for (int i = 0; i < 4; i++) step(0, 1, 10, 10);
    for (int i = 0; i < 20; i++) frame($urandom_range(0, 3), 1'b1);

    repeat (4) @(posedge Clk);
    #3;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/duck_sprite_fetch.md
Name: duck_sprite_fetch

Overview:
- Per-pixel fetch-and-colour pipeline for the 20x20 duck sprite.
- Sits between the VGA scan counters (DrawX/DrawY) and the 5-bit-palette sprite frame RAM. It drives that RAM's read_address and consumes its registered data_Out.
- Selects the animation frame from a latched duck state, converts the palette index to 24-bit RGB, and flags transparency for the colour mapper.

Parameters:
- SPRITE_W, 20, sprite width in pixels.
- SPRITE_H, 20, sprite height in pixels.
- FLY_FRAMES, 3, number of flying animation frames (frames 0..FLY_FRAMES-1).
- ANIM_DIV, 8, vertical frames per animation step.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  vsync-rate strobe; its rising edge marks a new video frame.
- DrawX  in  10  current scan X.
- DrawY  in  10  current scan Y.
- duck_x  in  10  sprite top-left X.
- duck_y  in  10  sprite top-left Y.
- duck_state  in  2  00 FLYING, 01 SHOT, 10 FALLING, 11 HIDDEN.
- read_address  out  19  address to sprite frame RAM.
- data_In  in  5  palette index from RAM; valid one clock after read_address.
- sprite_on  out  1  opaque duck pixel at the delayed scan position.
- Red  out  8  pixel red.
- Green  out  8  pixel green.
- Blue  out  8  pixel blue.

Behaviour:
- Reset:
  - read_address, sprite_on, Red, Green, Blue = 0.
  - Frame index = 0; anim counter = 0; latched state = HIDDEN; latched position = 0.
  - frame_clk edge-detect history = 1, so a high frame_clk at reset release produces no edge.
- Frame latch: on a detected frame_clk rising edge (frame_clk = 1, previous = 0), register duck_x, duck_y and duck_state. The pipeline uses only the latched copies, so there is no mid-frame tearing.
- Animation, updated on the same edge, using the newly latched state:
  - FLYING: anim counter increments. At ANIM_DIV-1 the counter wraps to 0 and the frame index advances 0..FLY_FRAMES-1, wrapping to 0.
  - SHOT: frame index = FLY_FRAMES (3). Counter is held at 0.
  - FALLING: same counter rule, but the frame index alternates FLY_FRAMES+1 / FLY_FRAMES+2 (4/5). Entry from any other state starts at 4.
  - Entry into FLYING from any other state forces frame index 0 and counter 0.
  - HIDDEN: frame index and counter are held.
- Hit test (combinational):
  - dx = DrawX - duck_x and dy = DrawY - duck_y, each 11-bit signed.
  - hit = (0 <= dx < SPRITE_W) and (0 <= dy < SPRITE_H) and state != HIDDEN.
  - Negative dx/dy never hit. Boxes extending past 639/479 are clipped naturally.
- Pipeline (pixel presented in cycle k):
  - Edge k: read_address <= frame_index*SPRITE_W*SPRITE_H + dy*SPRITE_W + dx when hit, else read_address holds its previous value. hit1 <= hit.
  - Edge k+1: the RAM registers data_Out. hit2 <= hit1.
  - Edge k+2: sprite_on <= hit2 and (data_In != 0). RGB <= palette[data_In] when sprite_on, else 0.
  - Fixed latency: outputs for pixel k are valid after edge k+2, every cycle, with no stalls.
- Arithmetic: products are computed at 19 bits and truncated to 19. With the defaults, the maximum address is 5*400+399 = 2399.
- Palette (constant ROM):
  - 0 transparent
  - 1 = 000000
  - 2 = FFFFFF
  - 3 = 8B4513
  - 4 = 00A000
  - 5 = FFD000
  - 6..31 = 808080
- Simultaneous frame edge and pixel: the pixel in the edge cycle already uses the new latched values.
- Reset mid-frame: all pipeline stages clear on the same edge. The first valid output appears 3 edges after Reset deasserts.

Optional Feature:
- Macro DUCK_MIRROR_EN.
- When defined: add input port h_flip (1 bit), latched with the other inputs on the frame edge. When the latched h_flip = 1, the address uses dx' = SPRITE_W-1-dx instead of dx. Hit test, latency and all other behaviour are unchanged.
- When undefined: the port is absent and there is no flip logic.

Test Plan:
- Reset with frame_clk held high, release, hold frame_clk high for 5 cycles -> no frame edge detected; state stays HIDDEN; sprite_on = 0.
- Frame edge latching duck_x=100, duck_y=50, FLYING. Then DrawX=105, DrawY=52 -> read_address = 45 one edge later. With data_In=3 -> after edge k+2, sprite_on=1 and RGB = 8B/45/13.
- Same setup with DrawX=99 or DrawX=120 -> read_address unchanged from its previous value; sprite_on=0; RGB=0. data_In=0 inside the box -> sprite_on=0.
- FLYING for 24 frame edges with ANIM_DIV=8 -> frame index goes 0 to 1 at edge 8, 1 to 2 at edge 16, wraps 2 to 0 at edge 24. Pixel (0,0) address = 0/400/800.
- Switch to SHOT -> address base 1200. Then FALLING -> bases 1600/2000 alternating every 8 edges. Then HIDDEN -> sprite_on stays 0.
- Change duck_x mid-frame without a frame edge -> address still uses the old latched X until the next frame_clk rising edge.
